// File: rtl/slurm32_cpu_writeback.sv
// SLURM32 register-file write front end: ALU/load-return merge, load FIFO and pending-load scoreboard.
// Optional bypass outputs are built only when SLURM32_WB_FORWARD_EN is defined.
module slurm32_cpu_writeback #(
  parameter int REG_BITS = 8,
  parameter int BITS     = 32,
  parameter int LD_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RSTb,
  input  logic                        alu_wr_valid,
  input  logic [REG_BITS-1:0]         alu_wr_sel,
  input  logic [BITS-1:0]             alu_wr_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [REG_BITS-1:0]         ld_sel,
  input  logic [BITS-1:0]             ld_data,
  input  logic                        ld_issue,
  input  logic [REG_BITS-1:0]         ld_issue_sel,
  input  logic [REG_BITS-1:0]         hz_sel_a,
  input  logic [REG_BITS-1:0]         hz_sel_b,
  output logic                        hazard_a,
  output logic                        hazard_b,
  output logic [REG_BITS-1:0]         regIn_sel,
  output logic [BITS-1:0]             regIn_data,
  output logic [$clog2(LD_DEPTH):0]   ld_level,
  output logic                        waw_err,
  output logic                        fwd_a_valid,
  output logic                        fwd_b_valid,
  output logic [BITS-1:0]             fwd_a_data,
  output logic [BITS-1:0]             fwd_b_data
);

  localparam int NREG = 2 ** REG_BITS;
  localparam int AW   = $clog2(LD_DEPTH);
  localparam int LW   = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(LD_DEPTH);

  typedef struct packed {
    logic [REG_BITS-1:0] sel;
    logic [BITS-1:0]     data;
  } ld_entry_t;

  ld_entry_t           fifo_mem [LD_DEPTH];
  ld_entry_t           head;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [NREG-1:0]     pending_q, pending_d;
  logic [REG_BITS-1:0] regin_sel_q, regin_sel_d;
  logic [BITS-1:0]     regin_data_q, regin_data_d;
  logic                waw_err_q, waw_err_d;
  logic                push, pop;

  // Full blocks pushes outright, even when the same cycle pops.
  assign ld_ready = (level_q != DEPTH_L);
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_wr_valid && (level_q != '0);
  assign head     = fifo_mem[rd_ptr_q];

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{sel: ld_sel, data: ld_data};
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    pending_d    = pending_q;
    regin_sel_d  = '0;
    regin_data_d = '0;
    waw_err_d    = waw_err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (alu_wr_valid) begin
      regin_sel_d  = alu_wr_sel;
      regin_data_d = alu_wr_data;
    end else if (pop) begin
      regin_sel_d  = head.sel;
      regin_data_d = head.data;
    end

    // Clear first so a same-cycle issue to the same register wins.
    if (pop) begin
      pending_d[head.sel] = 1'b0;
    end
    if (ld_issue) begin
      pending_d[ld_issue_sel] = 1'b1;
    end
    pending_d[0] = 1'b0;

    if (alu_wr_valid && pending_q[alu_wr_sel] && (alu_wr_sel != '0)) begin
      waw_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pending_q    <= '0;
      regin_sel_q  <= '0;
      regin_data_q <= '0;
      waw_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      pending_q    <= pending_d;
      regin_sel_q  <= regin_sel_d;
      regin_data_q <= regin_data_d;
      waw_err_q    <= waw_err_d;
    end
  end

  assign hazard_a   = pending_q[hz_sel_a];
  assign hazard_b   = pending_q[hz_sel_b];
  assign regIn_sel  = regin_sel_q;
  assign regIn_data = regin_data_q;
  assign ld_level   = level_q;
  assign waw_err    = waw_err_q;

`ifdef SLURM32_WB_FORWARD_EN
  // Bypass covers the cycle in which the regfile is being written.
  always_comb begin
    fwd_a_valid = (hz_sel_a == regin_sel_q) && (regin_sel_q != '0);
    fwd_b_valid = (hz_sel_b == regin_sel_q) && (regin_sel_q != '0);
    fwd_a_data  = fwd_a_valid ? regin_data_q : '0;
    fwd_b_data  = fwd_b_valid ? regin_data_q : '0;
  end
`else
  assign fwd_a_valid = 1'b0;
  assign fwd_b_valid = 1'b0;
  assign fwd_a_data  = '0;
  assign fwd_b_data  = '0;
`endif

endmodule

// File: tb/tb_slurm32_cpu_writeback.sv
// Directed bench for slurm32_cpu_writeback: FIFO ordering, arbitration, scoreboard, waw_err, bypass, reset.
module tb_slurm32_cpu_writeback;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        alu_wr_valid;
  logic [7:0]  alu_wr_sel;
  logic [31:0] alu_wr_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_sel;
  logic [31:0] ld_data;
  logic        ld_issue;
  logic [7:0]  ld_issue_sel;
  logic [7:0]  hz_sel_a, hz_sel_b;
  logic        hazard_a, hazard_b;
  logic [7:0]  regIn_sel;
  logic [31:0] regIn_data;
  logic [2:0]  ld_level;
  logic        waw_err;
  logic        fwd_a_valid, fwd_b_valid;
  logic [31:0] fwd_a_data, fwd_b_data;

  int passed = 0;
  int total  = 0;

`ifdef SLURM32_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  slurm32_cpu_writeback #(.REG_BITS(8), .BITS(32), .LD_DEPTH(4)) dut (
    .CLK(CLK), .RSTb(RSTb),
    .alu_wr_valid(alu_wr_valid), .alu_wr_sel(alu_wr_sel), .alu_wr_data(alu_wr_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_data(ld_data),
    .ld_issue(ld_issue), .ld_issue_sel(ld_issue_sel),
    .hz_sel_a(hz_sel_a), .hz_sel_b(hz_sel_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .regIn_sel(regIn_sel), .regIn_data(regIn_data), .ld_level(ld_level), .waw_err(waw_err),
    .fwd_a_valid(fwd_a_valid), .fwd_b_valid(fwd_b_valid),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RSTb = 1'b0;
    alu_wr_valid = 1'b0; alu_wr_sel = '0; alu_wr_data = '0;
    ld_valid = 1'b0; ld_sel = '0; ld_data = '0;
    ld_issue = 1'b0; ld_issue_sel = '0;
    hz_sel_a = '0; hz_sel_b = '0;

    // Reset state
    #2;
    check("rst_sel",   32'(regIn_sel), 32'd0);
    check("rst_data",  regIn_data, 32'd0);
    check("rst_level", 32'(ld_level), 32'd0);
    check("rst_waw",   32'(waw_err), 32'd0);
    check("rst_fwd",   32'(fwd_a_valid), 32'd0);
    tick(); tick();
    RSTb = 1'b1;
    check("rst_ready", 32'(ld_ready), 32'd1);
    $display("reset released");

    // Single load, empty FIFO: no bypass, written one cycle later
    ld_valid = 1'b1; ld_sel = 8'd5; ld_data = 32'hDEADBEEF;
    tick();
    ld_valid = 1'b0;
    check("ld5_nobypass", 32'(regIn_sel), 32'd0);
    check("ld5_level1",   32'(ld_level), 32'd1);
    tick();
    check("ld5_sel",   32'(regIn_sel), 32'd5);
    check("ld5_data",  regIn_data, 32'hDEADBEEF);
    check("ld5_level0", 32'(ld_level), 32'd0);
    $display("single load sel=5 data=%h", regIn_data);

    // ALU burst of 6 with 5 load attempts; the fifth hits a full FIFO
    for (int i = 0; i < 6; i++) begin
      alu_wr_valid = 1'b1; alu_wr_sel = 8'(10 + i); alu_wr_data = 32'(32'h100 + i);
      ld_valid = (i < 5); ld_sel = 8'(20 + i); ld_data = 32'(32'hA0 + i);
      check("burst_ready", 32'(ld_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
      check("burst_sel",   32'(regIn_sel), 32'(10 + i));
      check("burst_data",  regIn_data, 32'(32'h100 + i));
      check("burst_level", 32'(ld_level), (i < 3) ? 32'(i + 1) : 32'd4);
      $display("alu burst %0d sel=%0d level=%0d", i, regIn_sel, ld_level);
    end
    alu_wr_valid = 1'b0;
    ld_valid = 1'b1; ld_sel = 8'd31; ld_data = 32'h31;
    check("full_pop_ready", 32'(ld_ready), 32'd0);
    tick();
    ld_valid = 1'b0;
    check("drain_sel0",   32'(regIn_sel), 32'd20);
    check("drain_data0",  regIn_data, 32'hA0);
    check("drain_level0", 32'(ld_level), 32'd3);
    for (int j = 1; j < 4; j++) begin
      tick();
      check("drain_sel",   32'(regIn_sel), 32'(20 + j));
      check("drain_data",  regIn_data, 32'(32'hA0 + j));
      check("drain_level", 32'(ld_level), 32'(3 - j));
      $display("drain %0d sel=%0d data=%h", j, regIn_sel, regIn_data);
    end
    tick();
    check("idle_sel",  32'(regIn_sel), 32'd0);
    check("idle_data", regIn_data, 32'd0);

    // Scoreboard set on issue, clear on pop
    ld_issue = 1'b1; ld_issue_sel = 8'd7; hz_sel_a = 8'd7;
    check("hz7_before", 32'(hazard_a), 32'd0);
    tick();
    ld_issue = 1'b0;
    check("hz7_set", 32'(hazard_a), 32'd1);
    ld_valid = 1'b1; ld_sel = 8'd7; ld_data = 32'h77;
    tick();
    ld_valid = 1'b0;
    check("hz7_queued", 32'(hazard_a), 32'd1);
    tick();
    check("hz7_popsel", 32'(regIn_sel), 32'd7);
    check("hz7_clear",  32'(hazard_a), 32'd0);
    ld_issue = 1'b1; ld_issue_sel = 8'd0; hz_sel_b = 8'd0;
    tick();
    ld_issue = 1'b0;
    check("hz0_never", 32'(hazard_b), 32'd0);
    $display("scoreboard sel=7 done");

    // Same-cycle set and clear of r9, then WAW
    ld_issue = 1'b1; ld_issue_sel = 8'd9; hz_sel_a = 8'd9;
    tick();
    ld_issue = 1'b0;
    check("hz9_set", 32'(hazard_a), 32'd1);
    ld_valid = 1'b1; ld_sel = 8'd9; ld_data = 32'h99;
    tick();
    ld_valid = 1'b0;
    ld_issue = 1'b1; ld_issue_sel = 8'd9;
    tick();
    ld_issue = 1'b0;
    check("hz9_popsel", 32'(regIn_sel), 32'd9);
    check("hz9_setwins", 32'(hazard_a), 32'd1);
    check("waw_before", 32'(waw_err), 32'd0);
    alu_wr_valid = 1'b1; alu_wr_sel = 8'd9; alu_wr_data = 32'h999;
    tick();
    alu_wr_valid = 1'b0;
    check("waw_set",  32'(waw_err), 32'd1);
    check("waw_data", regIn_data, 32'h999);
    tick(); tick();
    check("waw_sticky", 32'(waw_err), 32'd1);
    $display("waw_err=%0d", waw_err);

    // Bypass outputs
    alu_wr_valid = 1'b1; alu_wr_sel = 8'd3; alu_wr_data = 32'h1234; hz_sel_b = 8'd3;
    tick();
    alu_wr_valid = 1'b0;
    check("fwd_sel",    32'(regIn_sel), 32'd3);
    check("fwd_b_valid", 32'(fwd_b_valid), FWD ? 32'd1 : 32'd0);
    check("fwd_b_data",  fwd_b_data, FWD ? 32'h1234 : 32'd0);
    check("fwd_a_miss",  32'(fwd_a_valid), 32'd0);
    hz_sel_b = 8'd0;
    #1;
    check("fwd_b_sel0",  32'(fwd_b_valid), 32'd0);
    $display("bypass fwd_b_valid=%0d", fwd_b_valid);

    // Reset with three queued entries and a pending load
    ld_issue = 1'b1; ld_issue_sel = 8'd12; hz_sel_a = 8'd12;
    tick();
    ld_issue = 1'b0;
    check("pre_rst_hz", 32'(hazard_a), 32'd1);
    alu_wr_valid = 1'b1; alu_wr_sel = 8'd1; alu_wr_data = 32'h1;
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1; ld_sel = 8'(12 + k); ld_data = 32'(k);
      tick();
    end
    ld_valid = 1'b0;
    check("pre_rst_level", 32'(ld_level), 32'd3);
    RSTb = 1'b0;
    alu_wr_valid = 1'b0;
    #1;
    check("arst_level", 32'(ld_level), 32'd0);
    check("arst_sel",   32'(regIn_sel), 32'd0);
    check("arst_hz",    32'(hazard_a), 32'd0);
    check("arst_waw",   32'(waw_err), 32'd0);
    tick();
    RSTb = 1'b1;
    tick();
    check("post_rst_sel",   32'(regIn_sel), 32'd0);
    check("post_rst_level", 32'(ld_level), 32'd0);
    check("post_rst_ready", 32'(ld_ready), 32'd1);
    check("post_rst_hz",    32'(hazard_a), 32'd0);
    $display("reset mid-operation done");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
